// File: rtl/split_frame_ctrl.sv
// Frame sequencer for the K-row line-buffer chain (split): feeds pixels in,
// pops kernel columns out on a registered valid/ready stream, flushes leftover rows at frame end.
module split_frame_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int BURST_LENGTH  = 128,
    parameter int KERNEL_LENGTH = 3,
    parameter int MAX_ROWS      = 1024,
    parameter int RD_LATENCY    = 0,
    localparam int RW   = $clog2(MAX_ROWS + 1),
    localparam int COLW = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1,
    localparam int CW   = $clog2(BURST_LENGTH * MAX_ROWS + 1),
    localparam int KW   = KERNEL_LENGTH * DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [RW-1:0]         cfg_rows,
    output logic                  busy,
    output logic                  frame_done,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  sb_wen,
    output logic [DATA_WIDTH-1:0] sb_din,
    output logic                  sb_ren,
    output logic                  sb_clr,
    input  logic                  sb_full,
    input  logic                  sb_empty,
    input  logic                  sb_valid,
    input  logic [KW-1:0]         sb_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [KW-1:0]         m_data,
    output logic [COLW-1:0]       m_col,
    output logic [RW-1:0]         m_row,
    output logic                  m_last
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   in_cnt, in_total, pop_cnt, out_total;
    logic [COLW-1:0] pop_col, pend_col;
    logic [RW-1:0]   pop_row, pend_row;
    logic            pend, pend_last;
    logic            pop, pop_last, slot_free, m_hs;

    assign m_hs      = m_valid && m_ready;
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state == RUN) && !sb_full && (in_cnt < in_total);
    assign sb_wen    = s_valid && s_ready;
    assign sb_din    = s_data;
    // Only one column may be between split and the output register at a time.
    assign sb_ren    = (state == RUN) && slot_free && !pend && !sb_empty && (pop_cnt < out_total);
    assign pop       = sb_ren && sb_valid;
    assign pop_last  = (pop_cnt == out_total - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            sb_clr     <= 1'b0;
            in_cnt     <= '0;
            in_total   <= '0;
            pop_cnt    <= '0;
            out_total  <= '0;
            pop_col    <= '0;
            pop_row    <= '0;
            pend       <= 1'b0;
            pend_col   <= '0;
            pend_row   <= '0;
            pend_last  <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_col      <= '0;
            m_row      <= '0;
            m_last     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            sb_clr     <= 1'b0;
            if (m_hs) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (start && cfg_rows >= RW'(KERNEL_LENGTH)) begin
                        state     <= RUN;
                        busy      <= 1'b1;
                        in_cnt    <= '0;
                        pop_cnt   <= '0;
                        pop_col   <= '0;
                        pop_row   <= '0;
                        in_total  <= CW'(BURST_LENGTH) * CW'(cfg_rows);
                        out_total <= CW'(BURST_LENGTH) * CW'(cfg_rows - RW'(KERNEL_LENGTH - 1));
                    end
                end
                RUN: begin
                    if (sb_wen)
                        in_cnt <= in_cnt + CW'(1);
                    if (pop) begin
                        pop_cnt <= pop_cnt + CW'(1);
                        if (pop_col == COLW'(BURST_LENGTH - 1)) begin
                            pop_col <= '0;
                            pop_row <= pop_row + RW'(1);
                        end else begin
                            pop_col <= pop_col + COLW'(1);
                        end
                    end
                    if (m_hs && m_last) begin
                        state  <= FLUSH;
                        sb_clr <= 1'b1;
                    end
                end
                FLUSH: begin
                    state      <= DONE;
                    frame_done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
            if (RD_LATENCY == 0) begin
                if (pop) begin
                    m_valid <= 1'b1;
                    m_data  <= sb_dout;
                    m_col   <= pop_col;
                    m_row   <= pop_row;
                    m_last  <= pop_last;
                end
            end else begin
                // Column tag travels alongside the read so it lines up with sb_dout.
                if (pop) begin
                    pend      <= 1'b1;
                    pend_col  <= pop_col;
                    pend_row  <= pop_row;
                    pend_last <= pop_last;
                end
                if (pend) begin
                    pend    <= 1'b0;
                    m_valid <= 1'b1;
                    m_data  <= sb_dout;
                    m_col   <= pend_col;
                    m_row   <= pend_row;
                    m_last  <= pend_last;
                end
            end
        end
    end

endmodule

// File: tb/tb_split_frame_ctrl.sv
// Directed bench for split_frame_ctrl with a behavioural split line-buffer model and a column scoreboard.
module tb_split_frame_ctrl;
    localparam int DW  = 32;
    localparam int W   = 8;
    localparam int K   = 3;
    localparam int MR  = 16;
    localparam int RW  = $clog2(MR + 1);
    localparam int CLW = $clog2(W);

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [RW-1:0] cfg_rows = '0;
    logic busy, frame_done, s_valid = 1'b0, s_ready, sb_wen, sb_ren, sb_clr;
    logic [DW-1:0] s_data = '0, sb_din;
    logic sb_full, sb_empty, sb_valid, m_valid, m_ready = 1'b0, m_last;
    logic [K*DW-1:0] sb_dout, m_data;
    logic [CLW-1:0] m_col;
    logic [RW-1:0] m_row;

    split_frame_ctrl #(.DATA_WIDTH(DW), .BURST_LENGTH(W), .KERNEL_LENGTH(K), .MAX_ROWS(MR), .RD_LATENCY(0)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .busy(busy), .frame_done(frame_done),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .sb_wen(sb_wen), .sb_din(sb_din),
        .sb_ren(sb_ren), .sb_clr(sb_clr), .sb_full(sb_full), .sb_empty(sb_empty), .sb_valid(sb_valid),
        .sb_dout(sb_dout), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_col(m_col),
        .m_row(m_row), .m_last(m_last));

    always #5 clk = ~clk;

    // Split model: K chained rows of W words, a column is ready once K rows cover it.
    logic [DW-1:0] mem [0:255];
    int wr_n, rd_n;
    wire avail = (wr_n - rd_n) > (K - 1) * W;
    assign sb_full  = (wr_n - rd_n) >= K * W;
    assign sb_empty = !avail;
    assign sb_valid = sb_ren && avail;
    assign sb_dout  = {mem[8'(rd_n + 2 * W)], mem[8'(rd_n + W)], mem[8'(rd_n)]};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_n <= 0;
            rd_n <= 0;
        end else if (sb_clr) begin
            wr_n <= 0;
            rd_n <= 0;
        end else begin
            if (sb_wen) begin
                mem[8'(wr_n)] <= sb_din;
                wr_n <= wr_n + 1;
            end
            if (sb_valid) rd_n <= rd_n + 1;
        end
    end

    typedef struct packed {
        logic [K*DW-1:0] data;
        logic [CLW-1:0]  col;
        logic [RW-1:0]   row;
        logic            last;
    } col_t;

    col_t exp_q[$];
    logic [DW-1:0] feed_q[$];
    int checks = 0, errors = 0, cyc = 0, done_cnt = 0, clr_cnt = 0;
    int rdy_mode = 0, vld_mode = 0, pend_rows = 0;
    bit pend_start = 0, held = 0, full_seen = 0;
    col_t held_v;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue a frame's pixels and, optionally, every column it should produce.
    task automatic load_frame(input int h, input int base, input bit push_exp);
        col_t e;
        feed_q.delete();
        for (int n = 0; n < W * h; n++) feed_q.push_back(DW'(base + n));
        if (push_exp)
            for (int r = 0; r <= h - K; r++)
                for (int c = 0; c < W; c++) begin
                    e.data = {DW'(base + (r + 2) * W + c), DW'(base + (r + 1) * W + c), DW'(base + r * W + c)};
                    e.col  = CLW'(c);
                    e.row  = RW'(r);
                    e.last = (r == h - K) && (c == W - 1);
                    exp_q.push_back(e);
                end
    endtask

    task automatic tick();
        col_t got, e;
        @(negedge clk);
        cyc++;
        start = pend_start;
        cfg_rows = RW'(pend_rows);
        pend_start = 0;
        s_valid = (feed_q.size() > 0) && (vld_mode == 0 || $urandom_range(1, 0) == 1);
        s_data = (feed_q.size() > 0) ? feed_q[0] : '0;
        m_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (cyc % 3 == 0) : 1'b0;
        #1;
        if (frame_done) done_cnt++;
        if (sb_clr) clr_cnt++;
        if (sb_full) begin
            full_seen = 1;
            check("full_blocks_s_ready", s_ready, 0);
        end
        got = {m_data, m_col, m_row, m_last};
        if (held) check("stall_hold", {m_valid, got}, {1'b1, held_v});
        held = m_valid && !m_ready;
        held_v = got;
        if (s_valid && s_ready) void'(feed_q.pop_front());
        if (m_valid && m_ready) begin
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_column: observed %0h expected none", got);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("column", got, e);
            end
        end
    endtask

    task automatic run_done(input int maxc);
        int n = 0;
        while (!(exp_q.size() == 0 && done_cnt > 0) && n < maxc) begin
            tick();
            n++;
        end
        check("frame_completes_in_budget", n < maxc, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_outputs", {busy, frame_done, s_ready, sb_wen, sb_ren, sb_clr, m_valid, m_last, m_data, m_col, m_row}, 0);
        rst = 0;

        // T1: async reset mid-frame
        load_frame(4, 0, 0);
        rdy_mode = 2;
        pend_rows = 4; pend_start = 1;
        for (int i = 0; i < 100 && feed_q.size() > W * 4 - 10; i++) tick();
        check("t1_ten_accepted", feed_q.size(), W * 4 - 10);
        check("t1_busy_running", busy, 1);
        @(negedge clk);
        s_valid = 0;
        #2 rst = 1;
        #1 check("t1_async_reset", {busy, frame_done, s_ready, sb_wen, sb_ren, sb_clr, m_valid, m_last, m_data, m_col, m_row}, 0);
        feed_q.delete(); exp_q.delete(); held = 0;
        @(negedge clk) rst = 0;

        // T2: clean frame H=4, always ready
        done_cnt = 0; clr_cnt = 0; rdy_mode = 0;
        load_frame(4, 0, 1);
        pend_rows = 4; pend_start = 1;
        run_done(2000);
        tick(); tick();
        check("t2_busy_low", busy, 0);
        check("t2_done_once", done_cnt, 1);
        check("t2_clr_once", clr_cnt, 1);
        check("t2_all_columns", exp_q.size(), 0);

        // T3: downstream ready 1-of-3
        done_cnt = 0; rdy_mode = 1;
        load_frame(4, 0, 1);
        pend_rows = 4; pend_start = 1;
        run_done(3000);
        tick(); tick();
        check("t3_done_once", done_cnt, 1);
        check("t3_all_columns", exp_q.size(), 0);

        // T4: input stalls, downstream blocked until split fills
        done_cnt = 0; rdy_mode = 2; vld_mode = 1; full_seen = 0;
        load_frame(6, 200, 1);
        pend_rows = 6; pend_start = 1;
        repeat (120) tick();
        check("t4_split_filled", full_seen, 1);
        check("t4_nothing_consumed", exp_q.size(), 32);
        rdy_mode = 0;
        run_done(3000);
        tick(); tick();
        check("t4_feed_drained", feed_q.size(), 0);
        check("t4_done_once", done_cnt, 1);
        vld_mode = 0;

        // T5: short frame rejected; start while busy ignored
        done_cnt = 0;
        pend_rows = 2; pend_start = 1;
        repeat (4) tick();
        check("t5_short_start_busy", busy, 0);
        check("t5_short_no_done", done_cnt, 0);
        load_frame(4, 300, 1);
        pend_rows = 4; pend_start = 1;
        repeat (20) tick();
        pend_rows = 5; pend_start = 1;
        tick();
        check("t5_busy_kept", busy, 1);
        run_done(2000);
        tick(); tick();
        check("t5_done_once", done_cnt, 1);
        check("t5_all_columns", exp_q.size(), 0);

        // T6: two H=3 frames back-to-back
        done_cnt = 0; clr_cnt = 0;
        load_frame(3, 400, 1);
        pend_rows = 3; pend_start = 1;
        run_done(2000);
        check("t6_clr_after_first", clr_cnt, 1);
        tick();
        done_cnt = 0;
        load_frame(3, 600, 1);
        pend_rows = 3; pend_start = 1;
        run_done(2000);
        tick(); tick();
        check("t6_clr_total", clr_cnt, 2);
        check("t6_second_columns", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
